// File: rtl/game_round_ctrl.sv
// Game-round sequencer for the VGA game page.
// Debounces the five push-keys and runs the IDLE / COUNTDOWN / PLAY / RESULT
// round machine. It produces the BCD display word, a hit pulse and the game tick.
module game_round_ctrl #(
  parameter int TICK_DIV     = 25_000_000,
  parameter int DEBOUNCE_CYC = 250_000,
  parameter int PLAY_SEC     = 9,
  parameter int RESULT_SEC   = 2
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic [4:0]  keys,
  output logic [15:0] disp_num,
  output logic [1:0]  game_state,
  output logic        hit,
  output logic        tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int RW = (RESULT_SEC > 1) ? $clog2(RESULT_SEC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CD     = 2'd1,
    S_PLAY   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // ---------------- key path ----------------
  logic [4:0] sync1_reg, sync2_reg;
  logic [4:0] press;

  // Two-flop synchroniser for the raw keys
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= keys;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_db
      logic [DW-1:0] cnt_reg;
      logic          level_reg;
      logic          press_reg;

      // Accept a new level after DEBOUNCE_CYC consecutive differing samples; pulse on accepted rise
      always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          press_reg <= 1'b0;
        end else begin
          press_reg <= 1'b0;
          if (sync2_reg[gi] == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DW'(DEBOUNCE_CYC - 1)) begin
            cnt_reg   <= '0;
            level_reg <= sync2_reg[gi];
            press_reg <= sync2_reg[gi];
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic confirm, up, down, abort;
  logic unused_press;
  assign confirm      = press[0];
  assign up           = press[1];
  assign down         = press[2];
  assign abort        = press[4];
  assign unused_press = press[3];

  // ---------------- LFSR ----------------
  logic [4:0] lfsr_reg;
  logic [3:0] lfsr_target;

  // Free-running x^5+x^3+1 sequence used to pick the target digit
  always_ff @(posedge vga_clk) begin
    if (vga_rst) lfsr_reg <= 5'h1F;
    else         lfsr_reg <= {lfsr_reg[3:0], lfsr_reg[4] ^ lfsr_reg[2]};
  end

  assign lfsr_target = (lfsr_reg[3:0] < 4'd10) ? lfsr_reg[3:0] : (lfsr_reg[3:0] - 4'd6);

  // ---------------- round machine ----------------
  state_t         state_reg, state_next;
  logic [1:0]     cd_reg, cd_next;
  logic [3:0]     digit_reg, digit_next;
  logic [3:0]     time_reg, time_next;
  logic [3:0]     target_reg, target_next;
  logic [7:0]     score_reg, score_next;
  logic [RW-1:0]  res_cnt_reg, res_cnt_next;
  logic [TW-1:0]  tick_cnt_reg, tick_cnt_next;
  logic           hit_reg, hit_next;
  logic           tick_reg;
  logic [15:0]    disp_reg, disp_next;
  logic           tick_wrap;
  logic [7:0]     score_inc;

  assign tick_wrap = (state_reg != S_IDLE) && (tick_cnt_reg == TW'(TICK_DIV - 1));

  // BCD increment that saturates at 99
  assign score_inc = (score_reg == 8'h99)     ? score_reg :
                     (score_reg[3:0] == 4'd9) ? {score_reg[7:4] + 4'd1, 4'd0} :
                                                {score_reg[7:4], score_reg[3:0] + 4'd1};

  // State register and all round datapath registers
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      state_reg    <= S_IDLE;
      cd_reg       <= 2'd0;
      digit_reg    <= 4'd0;
      time_reg     <= 4'd0;
      target_reg   <= 4'd0;
      score_reg    <= 8'h00;
      res_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
      hit_reg      <= 1'b0;
      tick_reg     <= 1'b0;
      disp_reg     <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      cd_reg       <= cd_next;
      digit_reg    <= digit_next;
      time_reg     <= time_next;
      target_reg   <= target_next;
      score_reg    <= score_next;
      res_cnt_reg  <= res_cnt_next;
      tick_cnt_reg <= tick_cnt_next;
      hit_reg      <= hit_next;
      tick_reg     <= tick_wrap;
      disp_reg     <= disp_next;
    end
  end

  // Next-state and datapath update; priority abort > confirm > expiry > up/down
  always_comb begin
    state_next   = state_reg;
    cd_next      = cd_reg;
    digit_next   = digit_reg;
    time_next    = time_reg;
    target_next  = target_reg;
    score_next   = score_reg;
    res_cnt_next = res_cnt_reg;
    hit_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (confirm) begin
          state_next = S_CD;
          score_next = 8'h00;
          cd_next    = 2'd3;
        end
      end
      S_CD: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (tick_wrap) begin
          if (cd_reg == 2'd1) begin
            state_next  = S_PLAY;
            target_next = lfsr_target;
            digit_next  = 4'd0;
            time_next   = 4'(PLAY_SEC);
          end else begin
            cd_next = cd_reg - 2'd1;
          end
        end
      end
      S_PLAY: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (confirm) begin
          state_next   = S_RESULT;
          res_cnt_next = '0;
          if (digit_reg == target_reg) begin
            score_next = score_inc;
            hit_next   = 1'b1;
          end
        end else if (tick_wrap && time_reg == 4'd1) begin
          state_next   = S_RESULT;
          res_cnt_next = '0;
          time_next    = 4'd0;
        end else begin
          if (tick_wrap) time_next = time_reg - 4'd1;
          if (up && !down)      digit_next = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
          else if (down && !up) digit_next = (digit_reg == 4'd0) ? 4'd9 : digit_reg - 4'd1;
        end
      end
      S_RESULT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (tick_wrap) begin
          if (res_cnt_reg == RW'(RESULT_SEC - 1)) begin
            state_next = S_CD;
            cd_next    = 2'd3;
          end else begin
            res_cnt_next = res_cnt_reg + RW'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next != state_reg || state_reg == S_IDLE) tick_cnt_next = '0;
    else if (tick_wrap)                                   tick_cnt_next = '0;
    else                                                  tick_cnt_next = tick_cnt_reg + TW'(1);
  end

  // Display word for the state being entered, registered alongside the state
  always_comb begin
    disp_next = {score_next, 8'h00};
    case (state_next)
      S_CD:     disp_next[7:0] = {6'd0, cd_next};
      S_PLAY:   disp_next[7:0] = {time_next, digit_next};
      S_RESULT: disp_next[7:0] = {4'h0, target_next};
      default:  disp_next[7:0] = 8'h00;
    endcase
  end

  assign disp_num   = disp_reg;
  assign game_state = state_reg;
  assign hit        = hit_reg;
  assign tick       = tick_reg;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed start-up steps followed by randomized rounds
// checked against a round-level model of score, digit and target.
module tb_game_round_ctrl;
  localparam int TD = 16;
  localparam int DB = 2;
  localparam int PS = 9;
  localparam int RS = 2;

  logic        vga_clk = 1'b0;
  logic        vga_rst = 1'b1;
  logic [4:0]  keys = 5'd0;
  logic [15:0] disp_num;
  logic [1:0]  game_state;
  logic        hit;
  logic        tick;

  int checks = 0;
  int errors = 0;

  game_round_ctrl #(
    .TICK_DIV(TD), .DEBOUNCE_CYC(DB), .PLAY_SEC(PS), .RESULT_SEC(RS)
  ) dut (
    .vga_clk(vga_clk), .vga_rst(vga_rst), .keys(keys),
    .disp_num(disp_num), .game_state(game_state), .hit(hit), .tick(tick)
  );

  always #5 vga_clk = ~vga_clk;

  // Reference bookkeeping: cycle count, LFSR sequence position, hit pulses
  int         cyc = 0;
  logic [4:0] lfsr_m = 5'h1F;
  logic [4:0] lfsr_prev = 5'h1F;
  int         hit_total = 0;
  int         hit_run = 0;
  int         hit_run_max = 0;

  function automatic logic [4:0] lfsr_step(input logic [4:0] l);
    return {l[3:0], l[4] ^ l[2]};
  endfunction

  function automatic int target_of(input logic [4:0] l);
    int v;
    v = int'(l) % 16;
    return (v < 10) ? v : v - 6;
  endfunction

  function automatic logic [7:0] bcd(input int s);
    return 8'((s / 10) * 16 + (s % 10));
  endfunction

  always @(posedge vga_clk) begin
    cyc       <= cyc + 1;
    lfsr_prev <= lfsr_m;
    lfsr_m    <= vga_rst ? 5'h1F : lfsr_step(lfsr_m);
    if (hit) begin
      hit_total <= hit_total + 1;
      hit_run   <= hit_run + 1;
      if (hit_run + 1 > hit_run_max) hit_run_max <= hit_run + 1;
    end else begin
      hit_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    @(negedge vga_clk);
    keys = m;
    repeat (hold) @(negedge vga_clk);
    keys = 5'd0;
    repeat (6) @(negedge vga_clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int n;
    n = 0;
    while (game_state !== s && n < budget) begin
      @(negedge vga_clk);
      n++;
    end
    chk("wait_state", 32'(game_state), 32'(s));
  endtask

  int score = 0;
  int digit = 0;
  int tgt = 0;
  int d = -1;
  int c_a, c0, n0, hits0, n, np, kind, outcome, want, u, exp_hit, prev_score;
  int rounds = 0;
  int sat = 0;

  initial begin
    // Reset held for three cycles
    vga_rst = 1'b1;
    repeat (3) @(negedge vga_clk);
    chk("reset_disp", 32'(disp_num), 32'h0);
    chk("reset_state", 32'(game_state), 32'd0);
    chk("reset_hit", 32'(hit), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    vga_rst = 1'b0;

    // One-cycle glitch on confirm must not start a round
    @(negedge vga_clk);
    keys = 5'h01;
    @(negedge vga_clk);
    keys = 5'h00;
    repeat (8) @(negedge vga_clk);
    chk("glitch_state", 32'(game_state), 32'd0);

    // Hold confirm 10 cycles; measure key-to-state latency
    @(negedge vga_clk);
    keys = 5'h01;
    c_a = cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge vga_clk);
      if (d < 0 && game_state == 2'd1) d = cyc - c_a;
    end
    keys = 5'h00;
    for (int i = 0; i < 30 && d < 0; i++) begin
      @(negedge vga_clk);
      if (game_state == 2'd1) d = cyc - c_a;
    end
    chk("start_state", 32'(game_state), 32'd1);
    chk("start_cd_digit", 32'(disp_num[3:0]), 32'd3);
    chk("start_score", 32'(disp_num[15:8]), 32'h00);
    $display("start: confirm latency %0d cycles", d);

    // First tick comes TICK_DIV cycles after state entry and decrements the countdown
    c0 = c_a + d;
    n = 0;
    while (tick !== 1'b1 && n < 3 * TD) begin
      @(negedge vga_clk);
      n++;
    end
    chk("first_tick_cyc", 32'(cyc - c0), 32'(TD));
    chk("cd_after_tick", 32'(disp_num[3:0]), 32'd2);

    // Randomized rounds until the score has been saturated twice
    while (rounds < 260 && !(score == 99 && sat >= 2)) begin
      wait_state(2'd2, 4 * TD + 8);
      n0    = cyc;
      tgt   = target_of(lfsr_prev);
      digit = 0;
      hits0 = hit_total;
      chk("play_entry", 32'(disp_num[7:0]), 32'(PS * 16));
      chk("play_score", 32'(disp_num[15:8]), 32'(bcd(score)));

      np = $urandom_range(0, 2);
      for (int i = 0; i < np; i++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: begin press(5'h02, 4);  digit = (digit + 1) % 10; end
          1: begin press(5'h04, 4);  digit = (digit + 9) % 10; end
          2: begin press(5'h06, 4); end
          default: begin press(5'h02, 15); digit = (digit + 1) % 10; end
        endcase
        chk("digit_keys", 32'(disp_num[3:0]), 32'(digit));
      end

      outcome = $urandom_range(0, 9);
      want = (outcome == 0) ? (tgt + $urandom_range(1, 9)) % 10 : tgt;
      u = (want - digit + 10) % 10;
      if (u <= 5) begin
        repeat (u) begin press(5'h02, 4); digit = (digit + 1) % 10; end
      end else begin
        repeat (10 - u) begin press(5'h04, 4); digit = (digit + 9) % 10; end
      end
      chk("digit_steer", 32'(disp_num[3:0]), 32'(digit));

      if (outcome == 1) begin
        wait_state(2'd3, PS * TD + 8);
        chk("expiry_cyc", 32'(cyc - n0), 32'(PS * TD));
      end else if (outcome == 2) begin
        while (cyc < n0 + PS * TD - d) @(negedge vga_clk);
        keys = 5'h01;
        wait_state(2'd3, 20);
        keys = 5'h00;
        chk("confirm_on_expiry_cyc", 32'(cyc - n0), 32'(PS * TD));
      end else begin
        press(5'h01, 4);
        chk("confirm_state", 32'(game_state), 32'd3);
      end
      @(negedge vga_clk);

      exp_hit = (outcome != 1 && digit == tgt) ? 1 : 0;
      prev_score = score;
      if (exp_hit == 1 && score < 99) score++;
      if (exp_hit == 1 && prev_score == 99) sat++;
      chk("hit_count", 32'(hit_total - hits0), 32'(exp_hit));
      chk("result_score", 32'(disp_num[15:8]), 32'(bcd(score)));
      chk("result_target", 32'(disp_num[7:0]), 32'(tgt));
      $display("round %0d: outcome %0d target %0d digit %0d hit %0d score %0d",
               rounds, outcome, tgt, digit, exp_hit, score);

      wait_state(2'd1, RS * TD + 8);
      chk("cd_restart", 32'(disp_num[7:0]), 32'd3);
      rounds++;
    end
    chk("score_saturated", 32'(score), 32'd99);
    chk("hit_width", 32'(hit_run_max), 32'd1);

    // Abort in PLAY returns to IDLE keeping the score, no hit
    wait_state(2'd2, 4 * TD + 8);
    hits0 = hit_total;
    press(5'h10, 4);
    chk("abort_state", 32'(game_state), 32'd0);
    chk("abort_disp", 32'(disp_num), 32'h9900);
    chk("abort_no_hit", 32'(hit_total - hits0), 32'd0);
    $display("abort: state %0d disp %h", game_state, disp_num);

    // New round from IDLE clears the score
    press(5'h01, 4);
    chk("restart_state", 32'(game_state), 32'd1);
    chk("restart_disp", 32'(disp_num), 32'h0003);

    // Reset mid-round clears everything
    wait_state(2'd2, 4 * TD + 8);
    repeat (3) @(negedge vga_clk);
    vga_rst = 1'b1;
    @(negedge vga_clk);
    chk("midreset_disp", 32'(disp_num), 32'h0);
    chk("midreset_state", 32'(game_state), 32'd0);
    chk("midreset_hit", 32'(hit), 32'd0);
    chk("midreset_tick", 32'(tick), 32'd0);
    repeat (2) @(negedge vga_clk);
    vga_rst = 1'b0;
    repeat (3) @(negedge vga_clk);
    chk("post_reset_state", 32'(game_state), 32'd0);
    $display("reset: state %0d disp %h", game_state, disp_num);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, observed state=%0d", game_state);
    $fatal(1, "timeout");
  end

endmodule
